// File: rtl/packet_gen_if.sv
// AXI-Stream bundle for the packet generator transmit port.
// The master drives payload and sideband; the slave returns tready.
interface packet_gen_if #(
  parameter int DW = 512
) ();
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [1:0]      tuser;
  logic            tlast;
  logic            tvalid;
  logic            tready;

  modport master (
    output tdata,
    output tkeep,
    output tuser,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tuser,
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/packet_gen.sv
// AXI-Stream traffic generator for the loopback path: emits runs of packets whose
// 64-bit lanes carry {sequence, lane index}; bytes outside tkeep are driven as zero.
module packet_gen #(
  parameter int DW = 512
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] packet_bytes,
  input  logic [31:0] packet_count,
  input  logic [15:0] gap_cycles,
  output logic        busy,
  output logic        done,
  output logic [31:0] packets_sent,
  packet_gen_if.master axis_tx
);

  localparam int BPB = DW / 8;
  localparam int LPB = DW / 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [31:0]     cfg_count_r, cfg_count_s;
  logic [15:0]     cfg_gap_r, cfg_gap_s;
  logic [15:0]     cfg_last_r, cfg_last_s;
  logic [15:0]     cfg_rem_r, cfg_rem_s;
  logic [31:0]     seq_r, seq_s;
  logic [31:0]     sent_r, sent_s;
  logic [15:0]     beat_r, beat_s;
  logic [15:0]     gap_cnt_r, gap_cnt_s;
  logic            stop_pend_r, stop_pend_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic            tvalid_r, tvalid_s;
  logic            tlast_r, tlast_s;
  logic [BPB-1:0]  tkeep_r, tkeep_s;
  logic [DW-1:0]   tdata_r, tdata_s;

  logic            hs_s;
  logic            run_end_s;
  logic            load_s;
  logic            clear_s;
  logic [15:0]     load_idx_s;
  logic [31:0]     load_seq_s;
  logic [15:0]     last_sel_s;
  logic [15:0]     rem_sel_s;
  logic [BPB-1:0]  keep_v_s;

  // Byte enables for one beat: only the final beat of a packet can be partial.
  function automatic logic [BPB-1:0] beat_keep(input logic [15:0] beat,
                                               input logic [15:0] last,
                                               input logic [15:0] rem);
    logic [BPB-1:0] k;
    for (int i = 0; i < BPB; i++) begin
      if ((beat == last) && (rem != 16'd0)) begin
        k[i] = (16'(i) < rem);
      end else begin
        k[i] = 1'b1;
      end
    end
    return k;
  endfunction

  // Self-describing payload with disabled bytes forced to zero.
  function automatic logic [DW-1:0] beat_data(input logic [31:0] seq,
                                              input logic [15:0] beat,
                                              input logic [BPB-1:0] keep);
    logic [DW-1:0] d;
    logic [31:0]   idx;
    for (int k = 0; k < LPB; k++) begin
      idx = 32'(beat) * 32'(LPB) + 32'(k);
      d[64*k +: 64] = {seq, idx};
    end
    for (int i = 0; i < BPB; i++) begin
      d[8*i +: 8] = keep[i] ? d[8*i +: 8] : 8'h00;
    end
    return d;
  endfunction

  assign hs_s      = tvalid_r & axis_tx.tready;
  assign run_end_s = ((cfg_count_r != 32'd0) && ((sent_r + 32'd1) == cfg_count_r))
                     || stop_pend_r || stop;

  // Next-state and next-output computation for the run controller.
  always_comb begin
    state_s     = state_r;
    cfg_count_s = cfg_count_r;
    cfg_gap_s   = cfg_gap_r;
    cfg_last_s  = cfg_last_r;
    cfg_rem_s   = cfg_rem_r;
    seq_s       = seq_r;
    sent_s      = sent_r;
    beat_s      = beat_r;
    gap_cnt_s   = gap_cnt_r;
    stop_pend_s = stop_pend_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
    tvalid_s    = tvalid_r;
    tlast_s     = tlast_r;
    tkeep_s     = tkeep_r;
    tdata_s     = tdata_r;
    load_s      = 1'b0;
    clear_s     = 1'b0;
    load_idx_s  = beat_r;
    load_seq_s  = seq_r;
    last_sel_s  = cfg_last_r;
    rem_sel_s   = cfg_rem_r;
    keep_v_s    = {BPB{1'b0}};

    case (state_r)
      ST_IDLE: begin
        if (start && (packet_bytes != 16'd0)) begin
          cfg_count_s = packet_count;
          cfg_gap_s   = gap_cycles;
          cfg_last_s  = (packet_bytes - 16'd1) / 16'(BPB);
          cfg_rem_s   = packet_bytes % 16'(BPB);
          last_sel_s  = cfg_last_s;
          rem_sel_s   = cfg_rem_s;
          sent_s      = 32'd0;
          seq_s       = 32'd0;
          stop_pend_s = 1'b0;
          busy_s      = 1'b1;
          state_s     = ST_SEND;
          load_s      = 1'b1;
          load_idx_s  = 16'd0;
          load_seq_s  = 32'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SEND: begin
        stop_pend_s = stop_pend_r | stop;
        if (hs_s && !tlast_r) begin
          load_s     = 1'b1;
          load_idx_s = beat_r + 16'd1;
        end else if (hs_s) begin
          // Completion is only evaluated at the tlast handshake, so packets are never cut short.
          sent_s = sent_r + 32'd1;
          seq_s  = seq_r + 32'd1;
          if (run_end_s) begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            clear_s = 1'b1;
          end else if (cfg_gap_r == 16'd0) begin
            load_s     = 1'b1;
            load_idx_s = 16'd0;
            load_seq_s = seq_r + 32'd1;
          end else begin
            state_s   = ST_GAP;
            gap_cnt_s = cfg_gap_r;
            clear_s   = 1'b1;
          end
        end else begin
          state_s = ST_SEND;
        end
      end

      ST_GAP: begin
        if (stop) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          clear_s = 1'b1;
        end else if (gap_cnt_r == 16'd1) begin
          state_s    = ST_SEND;
          load_s     = 1'b1;
          load_idx_s = 16'd0;
        end else begin
          gap_cnt_s = gap_cnt_r - 16'd1;
        end
      end

      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        clear_s = 1'b1;
      end
    endcase

    if (load_s) begin
      keep_v_s = beat_keep(load_idx_s, last_sel_s, rem_sel_s);
      tdata_s  = beat_data(load_seq_s, load_idx_s, keep_v_s);
      tkeep_s  = keep_v_s;
      tlast_s  = (load_idx_s == last_sel_s);
      tvalid_s = 1'b1;
      beat_s   = load_idx_s;
    end else if (clear_s) begin
      tdata_s  = {DW{1'b0}};
      tkeep_s  = {BPB{1'b0}};
      tlast_s  = 1'b0;
      tvalid_s = 1'b0;
    end else begin
      tvalid_s = tvalid_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      cfg_count_r <= 32'd0;
      cfg_gap_r   <= 16'd0;
      cfg_last_r  <= 16'd0;
      cfg_rem_r   <= 16'd0;
      seq_r       <= 32'd0;
      sent_r      <= 32'd0;
      beat_r      <= 16'd0;
      gap_cnt_r   <= 16'd0;
      stop_pend_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      tvalid_r    <= 1'b0;
      tlast_r     <= 1'b0;
      tkeep_r     <= {BPB{1'b0}};
      tdata_r     <= {DW{1'b0}};
    end else begin
      state_r     <= state_s;
      cfg_count_r <= cfg_count_s;
      cfg_gap_r   <= cfg_gap_s;
      cfg_last_r  <= cfg_last_s;
      cfg_rem_r   <= cfg_rem_s;
      seq_r       <= seq_s;
      sent_r      <= sent_s;
      beat_r      <= beat_s;
      gap_cnt_r   <= gap_cnt_s;
      stop_pend_r <= stop_pend_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      tvalid_r    <= tvalid_s;
      tlast_r     <= tlast_s;
      tkeep_r     <= tkeep_s;
      tdata_r     <= tdata_s;
    end
  end

  assign busy           = busy_r;
  assign done           = done_r;
  assign packets_sent   = sent_r;
  assign axis_tx.tdata  = tdata_r;
  assign axis_tx.tkeep  = tkeep_r;
  assign axis_tx.tuser  = 2'b00;
  assign axis_tx.tlast  = tlast_r;
  assign axis_tx.tvalid = tvalid_r;

endmodule

// File: tb/tb_packet_gen.sv
// Scoreboard bench for packet_gen: expected beats come from a byte-level model of the
// payload rules; a monitor pops and compares on every handshake.
module tb_packet_gen;
  localparam int DW  = 512;
  localparam int BPB = DW / 8;
  localparam int LPB = DW / 64;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        stop;
  logic [15:0] packet_bytes;
  logic [31:0] packet_count;
  logic [15:0] gap_cycles;
  logic        busy;
  logic        done;
  logic [31:0] packets_sent;

  packet_gen_if #(.DW(DW)) axis_tx ();

  packet_gen #(.DW(DW)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .stop         (stop),
    .packet_bytes (packet_bytes),
    .packet_count (packet_count),
    .gap_cycles   (gap_cycles),
    .busy         (busy),
    .done         (done),
    .packets_sent (packets_sent),
    .axis_tx      (axis_tx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [BPB-1:0] keep;
    logic           last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    hs_count = 0;
  int    done_seen = 0;
  int    done_base = 0;
  int    exp_beats = 0;
  int    exp_final = 0;
  int    cur_gap = 0;
  bit    rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: byte n of the packet is valid iff n < packet_bytes; lane = {seq, global lane no}.
  function automatic beat_t model_beat(input int bytes, input int unsigned seq, input int b);
    beat_t       r;
    int          vb;
    logic [31:0] s32;
    logic [31:0] idx;
    vb = bytes - b * BPB;
    if (vb > BPB) vb = BPB;
    s32 = seq;
    r.data = '0;
    for (int k = 0; k < LPB; k++) begin
      idx = 32'(b * LPB + k);
      r.data[64*k +: 64] = {s32, idx};
    end
    for (int i = 0; i < BPB; i++) begin
      r.keep[i] = (i < vb);
      if (i >= vb) r.data[8*i +: 8] = 8'h00;
    end
    r.last = ((b + 1) * BPB >= bytes);
    return r;
  endfunction

  task automatic push_packet(input int bytes, input int unsigned seq);
    for (int b = 0; b * BPB < bytes; b++) exp_q.push_back(model_beat(bytes, seq, b));
  endtask

  // tready source: always 1, or a fair coin per cycle.
  initial begin
    axis_tx.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      axis_tx.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pop, AXIS stability, gap length and done/packets_sent checks.
  initial begin
    beat_t          e;
    logic [DW-1:0]  h_data;
    logic [BPB-1:0] h_keep;
    logic           h_last;
    bit             stalled, in_gap, prev_last_hs, hs;
    int             gap_cnt;
    stalled = 0; in_gap = 0; prev_last_hs = 0; gap_cnt = 0;
    h_data = '0; h_keep = '0; h_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        stalled = 0; in_gap = 0; prev_last_hs = 0;
      end else begin
        if (stalled) begin
          check("stall_tvalid", 64'(axis_tx.tvalid), 64'd1);
          checks++;
          if (axis_tx.tdata !== h_data || axis_tx.tkeep !== h_keep || axis_tx.tlast !== h_last) begin
            errors++;
            $display("FAIL stall_stable: beat changed while stalled, tdata %h, held %h", axis_tx.tdata, h_data);
          end
        end
        if (in_gap) begin
          if (axis_tx.tvalid) begin
            check("gap_len", 64'(gap_cnt), 64'(cur_gap));
            in_gap = 0;
          end else if (!busy) begin
            in_gap = 0;
          end else begin
            gap_cnt++;
          end
        end
        if (done) begin
          done_seen++;
          check("done_after_tlast", 64'(prev_last_hs), 64'd1);
          check("done_packets_sent", 64'(packets_sent), 64'(exp_final));
          check("done_busy", 64'(busy), 64'd0);
          check("done_tvalid", 64'(axis_tx.tvalid), 64'd0);
        end
        hs = axis_tx.tvalid && axis_tx.tready;
        if (hs) begin
          hs_count++;
          check("tuser", 64'(axis_tx.tuser), 64'd0);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got tdata %h with nothing expected", axis_tx.tdata);
          end else begin
            e = exp_q.pop_front();
            checks++;
            if (axis_tx.tdata !== e.data || axis_tx.tkeep !== e.keep || axis_tx.tlast !== e.last) begin
              errors++;
              $display("FAIL beat: got keep %h last %b data %h, expected keep %h last %b data %h",
                       axis_tx.tkeep, axis_tx.tlast, axis_tx.tdata[255:0], e.keep, e.last, e.data[255:0]);
            end
          end
        end
        stalled = axis_tx.tvalid && !axis_tx.tready;
        h_data = axis_tx.tdata; h_keep = axis_tx.tkeep; h_last = axis_tx.tlast;
        prev_last_hs = hs && axis_tx.tlast;
        if (prev_last_hs) begin
          in_gap = 1; gap_cnt = 0;
        end
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_packets_sent", 64'(packets_sent), 64'd0);
    check("rst_tvalid", 64'(axis_tx.tvalid), 64'd0);
    check("rst_tlast", 64'(axis_tx.tlast), 64'd0);
    check("rst_tkeep", 64'(axis_tx.tkeep), 64'd0);
    check("rst_tuser", 64'(axis_tx.tuser), 64'd0);
    check("rst_tdata_zero", 64'(axis_tx.tdata == '0), 64'd1);
  endtask

  task automatic start_run(input int bytes, input int unsigned count, input int gap,
                           input int npush, input int final_sent);
    @(posedge clk);
    #1;
    packet_bytes = 16'(bytes);
    packet_count = count;
    gap_cycles   = 16'(gap);
    cur_gap      = gap;
    exp_final    = final_sent;
    hs_count     = 0;
    done_base    = done_seen;
    for (int p = 0; p < npush; p++) push_packet(bytes, p);
    exp_beats = exp_q.size();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    packet_bytes = 16'($urandom);
    packet_count = $urandom;
    gap_cycles   = 16'($urandom);
    @(negedge clk);
    check("start_busy", 64'(busy), 64'd1);
    check("start_tvalid", 64'(axis_tx.tvalid), 64'd1);
  endtask

  task automatic wait_hs(input int target, input int limit);
    int n = 0;
    while (hs_count < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("wait_hs_timeout", 64'(hs_count >= target), 64'd1);
  endtask

  task automatic finish_run(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", 64'(n < limit), 64'd1);
    repeat (5) @(negedge clk);
    check("done_once", 64'(done_seen - done_base), 64'd1);
    check("beat_total", 64'(hs_count), 64'(exp_beats));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_packets_sent", 64'(packets_sent), 64'(exp_final));
    check("final_busy", 64'(busy), 64'd0);
    check("final_tvalid", 64'(axis_tx.tvalid), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int bytes, cnt, gap;
    resetn = 1'b0; start = 1'b0; stop = 1'b0;
    packet_bytes = 16'd0; packet_count = 32'd0; gap_cycles = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check_reset_vals();

    // Zero-length start is ignored.
    @(posedge clk); #1;
    packet_bytes = 16'd0; packet_count = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_len_ignored", 64'(busy), 64'd0);

    start_run(64, 1, 0, 1, 1);
    finish_run(200);

    start_run(130, 2, 0, 2, 2);
    finish_run(200);

    rand_ready = 1'b1;
    start_run(1000, 4, 0, 4, 4);
    repeat (10) @(posedge clk);
    #1;
    packet_bytes = 16'd64; packet_count = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_run(2000);
    rand_ready = 1'b0;

    start_run(64, 3, 3, 3, 3);
    finish_run(200);

    start_run(256, 0, 0, 6, 6);
    wait_hs(5 * 4 + 1, 500);
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    finish_run(500);

    start_run(1000, 2, 0, 2, 0);
    wait_hs(5, 200);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_reset_vals();
    start_run(64, 1, 0, 1, 1);
    finish_run(200);

    rand_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      bytes = int'($urandom_range(1, 300));
      cnt   = int'($urandom_range(1, 3));
      gap   = int'($urandom_range(0, 3));
      start_run(bytes, cnt, gap, cnt, cnt);
      finish_run(2000);
    end
    rand_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
